// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard
//   Producer side of the operand-forwarding interface. Tracks the destination register,
//   write-enable and load flag of the instructions in EX, MEM and WB, publishes them to
//   the forwarding logic, and detects load-use hazards that forwarding cannot cover.
//   On a load-use hazard it stalls decode and injects one bubble into EX. A saturating
//   counter records load-use stall cycles for performance monitoring.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   id_valid        decode holds a valid instruction
//   id_instr        decode instruction (opcode [15:11], Rs [10:8], Rt [7:5])
//   id_reg_wrt      decode instruction writes a register
//   id_mem_read     decode instruction is a load
//   id_target_reg   decode instruction destination register
//   stall_ext       external freeze; all stages and the counter hold
//   flush           kill the instruction leaving decode
//   ex_*/mem_*/wb_* per-stage write-enable, destination and (EX only) load flag
//   id_stall        combinational load-use stall request for PC and IF/ID
//   stall_cnt       saturating count of load-use stall cycles
module pipeline_scoreboard #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [15:0]      id_instr,
  input  logic             id_reg_wrt,
  input  logic             id_mem_read,
  input  logic [2:0]       id_target_reg,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             ex_wrt,
  output logic [2:0]       ex_target,
  output logic             ex_mem_read,
  output logic             mem_wrt,
  output logic [2:0]       mem_target,
  output logic             wb_wrt,
  output logic [2:0]       wb_target,
  output logic             id_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       wrt;
    logic [2:0] target;
    logic       mem_read;
  } stage_t;

  localparam stage_t Bubble = '0;

  stage_t           ex_q, mem_q, wb_q;
  stage_t           ex_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [4:0] op;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       rs_used;
  logic       rt_used;
  logic       rs_hit;
  logic       rt_hit;

  // The immediate/function bits of the instruction carry no register operands.
  logic unused_instr_bits;
  assign unused_instr_bits = ^id_instr[4:0];

  assign op = id_instr[15:11];
  assign rs = id_instr[10:8];
  assign rt = id_instr[7:5];

  // Operand-use decode: which source fields actually read the register file.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    if (id_valid) begin
      case (op)
        5'b00000, 5'b00001, 5'b00010, 5'b00011,
        5'b00100, 5'b00110, 5'b11000: rs_used = 1'b0;
        default:                      rs_used = 1'b1;
      endcase
      rt_used = ((op[4:3] == 2'b11) && (op != 5'b11000) && (op != 5'b11001)) ||
                (op == 5'b10000) || (op == 5'b10011);
    end
  end

  // A load in EX has no data yet; any consumer in decode must wait one cycle.
  assign rs_hit   = rs_used && (rs == ex_q.target);
  assign rt_hit   = rt_used && (rt == ex_q.target);
  assign id_stall = ex_q.wrt && ex_q.mem_read && (rs_hit || rt_hit);

  // Flush, stall and an empty decode slot all collapse into the same single bubble.
  always_comb begin
    ex_d = Bubble;
    if (id_valid && !flush && !id_stall) begin
      ex_d.wrt      = id_reg_wrt;
      // Keep the destination clean for non-writers so comparators never see stale tags.
      ex_d.target   = id_reg_wrt ? id_target_reg : 3'b000;
      ex_d.mem_read = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= Bubble;
      mem_q <= Bubble;
      wb_q  <= Bubble;
    end else if (!stall_ext) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (id_stall && !stall_ext && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign ex_wrt      = ex_q.wrt;
  assign ex_target   = ex_q.target;
  assign ex_mem_read = ex_q.mem_read;
  assign mem_wrt     = mem_q.wrt;
  assign mem_target  = mem_q.target;
  assign wb_wrt      = wb_q.wrt;
  assign wb_target   = wb_q.target;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: reset sequence, a table of directed
// vectors covering flow, load-use, false-stall cases, freeze and flush, then randomized
// traffic against a queue-based reference model and a counter saturation run on a
// narrow-counter instance that shares the same stimulus.
module tb_pipeline_scoreboard;

  localparam logic [4:0] OpAdd = 5'b11011;
  localparam logic [4:0] OpLd  = 5'b10001;
  localparam logic [4:0] OpJ   = 5'b00100;
  localparam logic [4:0] OpLbi = 5'b11000;
  localparam logic [4:0] OpSt  = 5'b10000;
  localparam logic [4:0] OpNop = 5'b00001;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_reg_wrt, id_mem_read, stall_ext, flush;
  logic [15:0] id_instr;
  logic [2:0]  id_target_reg;

  logic        ex_wrt, ex_mem_read, mem_wrt, wb_wrt, id_stall;
  logic [2:0]  ex_target, mem_target, wb_target;
  logic [15:0] stall_cnt;

  logic        s_ex_wrt, s_ex_mem_read, s_mem_wrt, s_wb_wrt, s_id_stall;
  logic [2:0]  s_ex_target, s_mem_target, s_wb_target;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipeline_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_reg_wrt(id_reg_wrt), .id_mem_read(id_mem_read), .id_target_reg(id_target_reg),
    .stall_ext(stall_ext), .flush(flush), .ex_wrt(ex_wrt), .ex_target(ex_target),
    .ex_mem_read(ex_mem_read), .mem_wrt(mem_wrt), .mem_target(mem_target),
    .wb_wrt(wb_wrt), .wb_target(wb_target), .id_stall(id_stall), .stall_cnt(stall_cnt)
  );

  pipeline_scoreboard #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_reg_wrt(id_reg_wrt), .id_mem_read(id_mem_read), .id_target_reg(id_target_reg),
    .stall_ext(stall_ext), .flush(flush), .ex_wrt(s_ex_wrt), .ex_target(s_ex_target),
    .ex_mem_read(s_ex_mem_read), .mem_wrt(s_mem_wrt), .mem_target(s_mem_target),
    .wb_wrt(s_wb_wrt), .wb_target(s_wb_target), .id_stall(s_id_stall),
    .stall_cnt(s_stall_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt);
    return {op, rs, rt, 5'b00000};
  endfunction

  function automatic logic [12:0] st(input logic exw, input logic [2:0] ext, input logic exm,
                                     input logic mw, input logic [2:0] mt,
                                     input logic ww, input logic [2:0] wt);
    return {exw, ext, exm, mw, mt, ww, wt};
  endfunction

  function automatic logic [12:0] dut_stages();
    return {ex_wrt, ex_target, ex_mem_read, mem_wrt, mem_target, wb_wrt, wb_target};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       w;
    logic [2:0] t;
    logic       m;
  } ent_t;

  ent_t m_pipe[$];   // index 0 = EX, 1 = MEM, 2 = WB
  int   m_cnt;
  int   m_cnt_s;

  function automatic bit m_stall(input logic v, input logic [15:0] ins);
    logic [4:0] op;
    bit rs_u, rt_u;
    op   = ins[15:11];
    rs_u = v && !(op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd24});
    rt_u = v && ((op >= 5'd26) || (op == 5'd16) || (op == 5'd19));
    return m_pipe[0].w && m_pipe[0].m &&
           ((rs_u && ins[10:8] == m_pipe[0].t) || (rt_u && ins[7:5] == m_pipe[0].t));
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] ins, input logic w,
                       input logic [2:0] t, input logic m, input logic sx, input logic fl);
    rst = r; id_valid = v; id_instr = ins; id_reg_wrt = w;
    id_target_reg = t; id_mem_read = m; stall_ext = sx; flush = fl;
  endtask

  // One model-checked cycle: stall checked before the edge, state after it.
  task automatic cycle(input logic r, input logic v, input logic [15:0] ins, input logic w,
                       input logic [2:0] t, input logic m, input logic sx, input logic fl);
    bit   stl;
    ent_t e;
    drive(r, v, ins, w, t, m, sx, fl);
    #1;
    stl = m_stall(v, ins);
    chk("rnd_id_stall", {31'd0, id_stall}, {31'd0, stl});
    if (r) begin
      m_pipe = '{'0, '0, '0};
      m_cnt = 0;
      m_cnt_s = 0;
    end else if (!sx) begin
      e = '0;
      if (v && !fl && !stl) begin
        e.w = w;
        e.t = w ? t : 3'b000;
        e.m = m;
      end
      m_pipe.push_front(e);
      void'(m_pipe.pop_back());
      if (stl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
    @(posedge clk);
    #1;
    chk("rnd_stages", {19'd0, dut_stages()},
        {19'd0, m_pipe[0].w, m_pipe[0].t, m_pipe[0].m, m_pipe[1].w, m_pipe[1].t,
         m_pipe[2].w, m_pipe[2].t});
    chk("rnd_stall_cnt", {16'd0, stall_cnt}, m_cnt);
    chk("rnd_stall_cnt_small", {28'd0, s_stall_cnt}, m_cnt_s);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [15:0] ins;
    logic        w;
    logic [2:0]  t;
    logic        m;
    logic        sx;
    logic        fl;
    logic        exp_stall;
    logic [12:0] exp_st;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic v, input logic [15:0] ins, input logic w, input logic [2:0] t,
                      input logic m, input logic sx, input logic fl, input logic es,
                      input logic [12:0] est, input logic [15:0] ec);
    vec_t x;
    x.v = v; x.ins = ins; x.w = w; x.t = t; x.m = m; x.sx = sx; x.fl = fl;
    x.exp_stall = es; x.exp_st = est; x.exp_cnt = ec;
    vq.push_back(x);
  endtask

  initial begin
    logic [4:0] ops[10];
    logic [4:0] op;
    logic       w;

    // Flow of one writer, then load-use, non-stalling consumers, ST via Rt.
    addv(1, mk(OpAdd, 0, 0), 1, 3, 0, 0, 0, 0, st(1, 3, 0, 0, 0, 0, 0), 0);
    addv(1, mk(OpNop, 0, 0), 0, 0, 0, 0, 0, 0, st(0, 0, 0, 1, 3, 0, 0), 0);
    addv(1, mk(OpNop, 0, 0), 0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 1, 3), 0);
    addv(1, mk(OpNop, 0, 0), 0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0, 0), 0);
    addv(1, mk(OpLd, 1, 0),  1, 2, 1, 0, 0, 0, st(1, 2, 1, 0, 0, 0, 0), 0);
    addv(1, mk(OpAdd, 2, 5), 1, 4, 0, 0, 0, 1, st(0, 0, 0, 1, 2, 0, 0), 1);
    addv(1, mk(OpAdd, 2, 5), 1, 4, 0, 0, 0, 0, st(1, 4, 0, 0, 0, 1, 2), 1);
    addv(1, mk(OpLd, 1, 0),  1, 2, 1, 0, 0, 0, st(1, 2, 1, 1, 4, 0, 0), 1);
    addv(1, mk(OpJ, 2, 2),   0, 0, 0, 0, 0, 0, st(0, 0, 0, 1, 2, 1, 4), 1);
    addv(1, mk(OpLd, 1, 0),  1, 2, 1, 0, 0, 0, st(1, 2, 1, 0, 0, 1, 2), 1);
    addv(1, mk(OpLbi, 2, 2), 1, 2, 0, 0, 0, 0, st(1, 2, 0, 1, 2, 0, 0), 1);
    addv(1, mk(OpLd, 1, 0),  1, 2, 1, 0, 0, 0, st(1, 2, 1, 1, 2, 1, 2), 1);
    addv(1, mk(OpSt, 1, 2),  0, 0, 0, 0, 0, 1, st(0, 0, 0, 1, 2, 1, 2), 2);
    addv(1, mk(OpSt, 1, 2),  0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 1, 2), 2);
    // Freeze for three cycles with a pending load-use and flush toggling.
    addv(1, mk(OpLd, 1, 0),  1, 5, 1, 0, 0, 0, st(1, 5, 1, 0, 0, 0, 0), 2);
    addv(1, mk(OpAdd, 5, 0), 1, 6, 0, 1, 1, 1, st(1, 5, 1, 0, 0, 0, 0), 2);
    addv(1, mk(OpAdd, 5, 0), 1, 6, 0, 1, 0, 1, st(1, 5, 1, 0, 0, 0, 0), 2);
    addv(1, mk(OpAdd, 5, 0), 1, 6, 0, 1, 1, 1, st(1, 5, 1, 0, 0, 0, 0), 2);
    addv(1, mk(OpAdd, 5, 0), 1, 6, 0, 0, 0, 1, st(0, 0, 0, 1, 5, 0, 0), 3);
    // Flush of a valid writer, then flush coinciding with a load-use stall.
    addv(1, mk(OpAdd, 5, 0), 1, 6, 0, 0, 1, 0, st(0, 0, 0, 0, 0, 1, 5), 3);
    addv(1, mk(OpLd, 0, 0),  1, 1, 1, 0, 0, 0, st(1, 1, 1, 0, 0, 0, 0), 3);
    addv(1, mk(OpAdd, 1, 0), 1, 6, 0, 0, 1, 1, st(0, 0, 0, 1, 1, 0, 0), 4);
    // Invalid decode slot, then a non-writer whose target field is nonzero.
    addv(0, mk(OpAdd, 1, 0), 1, 7, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 1, 1), 4);
    addv(1, mk(OpNop, 0, 0), 0, 7, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0, 0), 4);

    // Reset held two cycles with a valid writer in decode.
    drive(1, 1, mk(OpAdd, 0, 0), 1, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset_stages", {19'd0, dut_stages()}, 32'd0);
      chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    end
    chk("reset_id_stall", {31'd0, id_stall}, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(0, vq[i].v, vq[i].ins, vq[i].w, vq[i].t, vq[i].m, vq[i].sx, vq[i].fl);
      #1;
      chk($sformatf("vec%0d_id_stall", i), {31'd0, id_stall}, {31'd0, vq[i].exp_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_stages", i), {19'd0, dut_stages()}, {19'd0, vq[i].exp_st});
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vq[i].exp_cnt});
    end

    // Randomized traffic against the model, starting from reset.
    ops = '{OpAdd, OpLd, OpJ, OpLbi, OpSt, OpNop, 5'b11001, 5'b10011, 5'b00110, 5'b01000};
    m_pipe = '{'0, '0, '0};
    m_cnt = 0;
    m_cnt_s = 0;
    cycle(1, 1, mk(OpNop, 0, 0), 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 9)];
      w  = (op == OpLd) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
            mk(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))), w,
            3'($urandom_range(0, 3)), (op == OpLd), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
    end

    // Saturation: 20 load-use pairs; the 4-bit counter must stop at 15.
    cycle(1, 0, mk(OpNop, 0, 0), 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, mk(OpLd, 0, 0), 1, 2, 1, 0, 0);
      cycle(0, 1, mk(OpAdd, 2, 0), 1, 3, 0, 0, 0);
    end
    chk("sat_small_cnt", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat_wide_cnt", {16'd0, stall_cnt}, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
